axi4lite_cmd_master: RTL and testbench
======================================

Name: axi4lite_cmd_master

Overview:
- Single-outstanding AXI4-Lite master that sits directly upstream of the 4 KB AXI4-Lite RAM slave.
- Converts a simple valid/ready command interface from test or crypto control logic into AXI4-Lite write and read transactions.
- Returns each result on a valid/ready response interface.
- Includes a response-timeout watchdog so a stuck slave cannot hang the issuer.

Parameters:
- DATA_WIDTH, 32, AXI data width (fixed at 32; WSTRB is 4 bits).
- TIMEOUT_CYCLES, 256, cycles to wait for BVALID/RVALID before flagging a timeout (≥2).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP; 2'b11 on timeout
- rsp_timeout  out  1  response produced by watchdog
- AWVALID/AWREADY/AWADDR[31:0], WVALID/WREADY/WDATA[31:0]/WSTRB[3:0], BVALID/BREADY/BRESP[1:0], ARVALID/ARREADY/ARADDR[31:0], RVALID/RREADY/RDATA[31:0]/RRESP[1:0]  AXI4-Lite master side (directions per AXI master).

Behaviour:
- All outputs are registered. Reset (ARESETn low at posedge ACLK) forces state IDLE and all VALID/READY outputs to 0, except cmd_ready=1. rsp_* data, AWADDR, WDATA, WSTRB and ARADDR reset to 0. Watchdog counter resets to 0.
- Reset mid-transaction aborts immediately; the issuer owns recovery.
- States:
  - IDLE: cmd_ready=1. On cmd handshake, latch the command and go to WR_REQ (write) or RD_REQ (read). cmd_ready drops the cycle after acceptance.
  - WR_REQ: AWVALID and WVALID are asserted together. Each deasserts independently on its own handshake (aw_done/w_done flags). When both are done, go to WR_RESP. Both may complete on the same edge.
  - WR_RESP: BREADY=1. On BVALID, capture BRESP, set rsp_rdata=0 and rsp_timeout=0, then go to RSP.
  - RD_REQ: ARVALID=1 until ARREADY, then go to RD_RESP.
  - RD_RESP: RREADY=1. On RVALID, capture RDATA and RRESP, then go to RSP.
  - RSP: rsp_valid=1 and held stable until rsp_ready. On handshake go to IDLE.
  - DRAIN: entered after a timed-out response is consumed (see watchdog). BREADY or RREADY stays high (matching the transaction type), cmd_ready=0. On the late BVALID/RVALID, discard the beat and go to IDLE.
- Watchdog:
  - Counts only in WR_RESP and RD_RESP; clears on entry to each.
  - On reaching TIMEOUT_CYCLES with no beat: set rsp_resp=2'b11, rsp_timeout=1, rsp_rdata=0, then RSP. After consumption, go to DRAIN rather than IDLE.
  - AW, W and AR valids are never withdrawn; the AXI VALID-stability rule holds unconditionally.
  - A beat arriving on the same edge the count expires wins: normal response, no timeout.
- AXI rules:
  - Address and data are stable while the corresponding VALID is high.
  - No VALID depends combinationally on any READY.
  - Only one transaction is outstanding at a time; the master never has AW/W and AR active simultaneously.
- Latency with a zero-wait slave (always-ready, B/R registered one cycle later):
  - cmd handshake at edge E0.
  - AW/W or AR handshake at E1.
  - B or R beat at E2.
  - rsp_valid visible after E2 (2 cycles).
  - Back-to-back throughput is one transaction per 4 cycles with rsp_ready held high.
- cmd_valid while busy: ignored (cmd_ready=0); no buffering.

Test Plan:
- Reset: hold ARESETn low 3 cycles → cmd_ready=1; AWVALID, WVALID, ARVALID, BREADY, RREADY and rsp_valid all 0.
- Write 0x00000010 ← 0xDEADBEEF, strb 4'hF, always-ready slave → one AW and one W handshake with that address/data. rsp_valid 2 cycles after cmd handshake, rsp_resp=00, rsp_timeout=0.
- Skewed handshakes: AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID held 4 cycles with AWADDR stable. Exactly one B accepted.
- Two reads against the incrementing-counter slave → rsp_rdata=0x00000000 then 0x00000004, RRESP=00. rsp_valid held 5 cycles while rsp_ready is low, data stable throughout.
- Slave never asserts BVALID, TIMEOUT_CYCLES=16 → rsp_valid with rsp_resp=11, rsp_timeout=1 at cycle 16 of WR_RESP. After consumption cmd_ready stays 0. A late BVALID is swallowed, then cmd_ready returns to 1.
- ARESETn pulsed low while in RD_RESP → next cycle in IDLE, RREADY=0, no rsp_valid emitted.

Source files
------------

// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: cmd valid/ready in, one AXI write or read out, result on rsp valid/ready.
// Zero-wait slave gives rsp_valid 2 cycles after cmd accept; cmd_ready low while busy, rsp held until rsp_ready.
module axi4lite_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [31:0]             cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [3:0]              cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [31:0]             AWADDR,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [3:0]              WSTRB,
  input  logic                    BVALID,
  output logic                    BREADY,
  input  logic [1:0]              BRESP,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic [31:0]             ARADDR,
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LP_WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN
  } state_t;

  state_t                  r_state;
  logic                    r_cmd_ready, r_awvalid, r_wvalid, r_bready;
  logic                    r_arvalid, r_rready, r_rsp_valid, r_rsp_timeout;
  logic [31:0]             r_awaddr, r_araddr;
  logic [DATA_WIDTH-1:0]   r_wdata, r_rsp_rdata;
  logic [3:0]              r_wstrb;
  logic [1:0]              r_rsp_resp;
  logic                    r_is_write, r_timed_out;
  logic [CW-1:0]           r_wd_cnt;

  // A channel counts as done once its valid has dropped or it handshakes this edge.
  logic w_aw_done, w_w_done;
  assign w_aw_done = !r_awvalid || AWREADY;
  assign w_w_done  = !r_wvalid  || WREADY;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b1;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= 2'b00;
      r_awaddr      <= '0;
      r_araddr      <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_is_write    <= 1'b0;
      r_timed_out   <= 1'b0;
      r_wd_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_is_write  <= cmd_write;
            r_timed_out <= 1'b0;
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (r_awvalid && AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && WREADY)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_wd_cnt <= '0;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (BVALID) begin
            r_bready      <= 1'b0;
            r_rsp_resp    <= BRESP;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RSP;
          end else if (r_wd_cnt == LP_WD_LAST) begin
            r_bready      <= 1'b0;
            r_rsp_resp    <= 2'b11;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
            r_timed_out   <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= RSP;
          end else begin
            r_wd_cnt <= r_wd_cnt + CW'(1);
          end
        end
        RD_REQ: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_wd_cnt  <= '0;
            r_state   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (RVALID) begin
            r_rready      <= 1'b0;
            r_rsp_resp    <= RRESP;
            r_rsp_rdata   <= RDATA;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RSP;
          end else if (r_wd_cnt == LP_WD_LAST) begin
            r_rready      <= 1'b0;
            r_rsp_resp    <= 2'b11;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
            r_timed_out   <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= RSP;
          end else begin
            r_wd_cnt <= r_wd_cnt + CW'(1);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            // A timed-out slave still owes a beat; swallow it before taking new work.
            if (r_timed_out) begin
              r_bready <= r_is_write;
              r_rready <= !r_is_write;
              r_state  <= DRAIN;
            end else begin
              r_cmd_ready <= 1'b1;
              r_state     <= IDLE;
            end
          end
        end
        DRAIN: begin
          if ((r_is_write && BVALID) || (!r_is_write && RVALID)) begin
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_resp    = r_rsp_resp;
  assign rsp_timeout = r_rsp_timeout;
  assign AWVALID     = r_awvalid;
  assign AWADDR      = r_awaddr;
  assign WVALID      = r_wvalid;
  assign WDATA       = r_wdata;
  assign WSTRB       = r_wstrb;
  assign BREADY      = r_bready;
  assign ARVALID     = r_arvalid;
  assign ARADDR      = r_araddr;
  assign RREADY      = r_rready;

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Bench for axi4lite_cmd_master: table of directed commands against a small AXI4-Lite slave model,
// plus hand sequences for watchdog/drain and reset during a read.
module tb_axi4lite_cmd_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_timeout;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi4lite_cmd_master #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  // Slave model: AW/W ready after a programmable number of waiting cycles,
  // B/R registered one cycle after the request, R data from an incrementing counter.
  int          aw_dly = 0, w_dly = 0;
  int          aw_wait = 0, w_wait = 0;
  int          b_cnt = 0, r_cnt = 0;
  logic        b_en = 1'b1, r_en = 1'b1;
  logic [1:0]  s_resp = 2'b00;
  logic        aw_got = 1'b0, w_got = 1'b0, s_bvalid = 1'b0, s_rvalid = 1'b0;
  logic [31:0] s_rdata = '0, s_rnext = '0, s_awaddr = '0, s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        aw_hs, w_hs;

  assign AWREADY = AWVALID && (aw_wait >= aw_dly);
  assign WREADY  = WVALID && (w_wait >= w_dly);
  assign ARREADY = 1'b1;
  assign BVALID  = s_bvalid;
  assign BRESP   = s_resp;
  assign RVALID  = s_rvalid;
  assign RDATA   = s_rdata;
  assign RRESP   = s_resp;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;

  always @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_wait <= 0; w_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      s_rnext <= '0;
    end else begin
      aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
      w_wait  <= (WVALID && !WREADY) ? w_wait + 1 : 0;
      if (aw_hs) begin aw_got <= 1'b1; s_awaddr <= AWADDR; end
      if (w_hs) begin w_got <= 1'b1; s_wdata <= WDATA; s_wstrb <= WSTRB; end
      if (b_en && (aw_got || aw_hs) && (w_got || w_hs)) begin
        s_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (s_bvalid && BREADY) begin s_bvalid <= 1'b0; b_cnt <= b_cnt + 1; end
      if (ARVALID && ARREADY && r_en) begin
        s_rvalid <= 1'b1; s_rdata <= s_rnext; s_rnext <= s_rnext + 32'd4;
      end
      if (s_rvalid && RREADY) begin s_rvalid <= 1'b0; r_cnt <= r_cnt + 1; end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  slv_resp;
    int          hold;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
    @(posedge ACLK);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat, aw_hi, w_hi, ar_hi, stab_err, b0, r0;
    lat = 0; aw_hi = 0; w_hi = 0; ar_hi = 0; stab_err = 0;
    b0 = b_cnt; r0 = r_cnt;
    aw_dly = v.aw_dly; w_dly = v.w_dly; s_resp = v.slv_resp;
    chk({tag, " cmd_ready idle"}, {31'd0, cmd_ready}, 32'd1);
    issue(v.wr, v.addr, v.wdata, v.wstrb);
    chk({tag, " cmd_ready busy"}, {31'd0, cmd_ready}, 32'd0);
    while (lat < 200) begin
      if (rsp_valid) break;
      if (AWVALID) begin aw_hi++; if (AWADDR !== v.addr) stab_err++; end
      if (WVALID) begin
        w_hi++;
        if (WDATA !== v.wdata || WSTRB !== v.wstrb) stab_err++;
      end
      if (ARVALID) begin ar_hi++; if (ARADDR !== v.addr) stab_err++; end
      if ((AWVALID || WVALID) && ARVALID) stab_err++;
      @(posedge ACLK); @(negedge ACLK);
      lat++;
    end
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " rsp_resp"}, {30'd0, rsp_resp}, {30'd0, v.exp_resp});
    chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " rsp_timeout"}, {31'd0, rsp_timeout}, 32'd0);
    chk({tag, " addr/data stable"}, stab_err, 0);
    if (v.wr) begin
      chk({tag, " awvalid cycles"}, aw_hi, v.aw_dly + 1);
      chk({tag, " wvalid cycles"}, w_hi, v.w_dly + 1);
      chk({tag, " b beats"}, b_cnt - b0, 1);
      chk({tag, " slave awaddr"}, s_awaddr, v.addr);
      chk({tag, " slave wdata"}, s_wdata, v.wdata);
      chk({tag, " slave wstrb"}, {28'd0, s_wstrb}, {28'd0, v.wstrb});
    end else begin
      chk({tag, " arvalid cycles"}, ar_hi, 1);
      chk({tag, " r beats"}, r_cnt - r0, 1);
    end
    for (int h = 0; h < v.hold; h++) begin
      @(posedge ACLK); @(negedge ACLK);
      chk({tag, " hold rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, " hold rsp_rdata"}, rsp_rdata, v.exp_rdata);
    end
    rsp_ready = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    rsp_ready = 1'b0;
    chk({tag, " rsp_valid after hs"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, " cmd_ready after hs"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat, bready_hi, b0, seen_rsp;
    vec_t rv;
    //           wr    addr          wdata         strb  awd wd resp  hold eresp erdata        lat
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 0, 2'b00, 32'h0000_0000, 2};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 2'b00, 0, 2'b00, 32'h0000_0000, 2};
    vecs[2] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 0, 0, 2'b00, 5, 2'b00, 32'h0000_0004, 2};
    vecs[3] = '{1'b1, 32'h0000_0014, 32'hA5A5_5A5A, 4'h3, 3, 0, 2'b00, 0, 2'b00, 32'h0000_0000, 5};
    vecs[4] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hC, 0, 2, 2'b10, 2, 2'b10, 32'h0000_0000, 4};
    vecs[5] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 0, 0, 2'b01, 0, 2'b01, 32'h0000_0008, 2};

    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset valids", {26'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 32'd0);
    chk("reset awaddr", AWADDR, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    ARESETn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Watchdog: slave never answers the write.
    aw_dly = 0; w_dly = 0; s_resp = 2'b00; b_en = 1'b0;
    b0 = b_cnt; lat = 0; bready_hi = 0;
    issue(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF);
    while (lat < 200) begin
      if (rsp_valid) break;
      if (BREADY) bready_hi++;
      @(posedge ACLK); @(negedge ACLK);
      lat++;
    end
    chk("to latency", lat, 17);
    chk("to bready cycles", bready_hi, 16);
    chk("to rsp_resp", {30'd0, rsp_resp}, 32'd3);
    chk("to rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    chk("to rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    rsp_ready = 1'b0;
    chk("drain rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("drain cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("drain bready", {31'd0, BREADY}, 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0080;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("drain ignores cmd", {30'd0, cmd_ready, ARVALID}, 32'd0);
    cmd_valid = 1'b0;
    b_en = 1'b1;
    seen_rsp = 0; lat = 0;
    while (lat < 20) begin
      if (cmd_ready) break;
      if (rsp_valid) seen_rsp++;
      @(posedge ACLK); @(negedge ACLK);
      lat++;
    end
    chk("drain cmd_ready back", {31'd0, cmd_ready}, 32'd1);
    chk("drain late b swallowed", b_cnt - b0, 1);
    chk("drain no rsp", seen_rsp, 0);
    chk("drain bready low", {31'd0, BREADY}, 32'd0);

    // Reset while waiting for R.
    r_en = 1'b0; s_resp = 2'b00;
    issue(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    lat = 0;
    while (lat < 20) begin
      if (RREADY) break;
      @(posedge ACLK); @(negedge ACLK);
      lat++;
    end
    chk("rst rd_resp rready", {31'd0, RREADY}, 32'd1);
    ARESETn = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    ARESETn = 1'b1;
    r_en = 1'b1;
    chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst rready/arvalid/rsp", {29'd0, RREADY, ARVALID, rsp_valid}, 32'd0);
    seen_rsp = 0;
    repeat (5) begin
      @(posedge ACLK); @(negedge ACLK);
      if (rsp_valid) seen_rsp++;
    end
    chk("rst no rsp emitted", seen_rsp, 0);
    rv = '{1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 0, 2'b00, 0, 2'b00, 32'h0000_0000, 2};
    run_vec("post_rst_rd", rv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
